// File: rtl/acl_filter_pkg.sv
// Shared definitions for the packed accelerometer word and the
// sample filter state machine.
package acl_filter_pkg;

    localparam int ACL_W  = 15;
    localparam int X_LO   = 0;
    localparam int Y_LO   = 15;
    localparam int Z_LO   = 30;
    localparam int PACK_W = 3 * ACL_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_ACCUM,
        ST_EMIT
    } acl_state_e;

endpackage

// File: rtl/acl_axis_accumulator.sv
// One axis of the averaging filter: sign-extending accumulator
// with an arithmetic-shift divide on the way out.
module acl_axis_accumulator
    import acl_filter_pkg::*;
#(
    parameter int WIDTH    = ACL_W,
    parameter int AVG_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample,
    input  logic             add,
    input  logic             clear,
    output logic [WIDTH-1:0] avg
);

    localparam int AW = WIDTH + AVG_LOG2;

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] acc_shr;

    assign sample_ext = {{AVG_LOG2{sample[WIDTH-1]}}, sample};

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = acc_q + sample_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Floor division; the mean of WIDTH-bit values always fits WIDTH bits.
    assign acc_shr = acc_q >>> AVG_LOG2;
    assign avg     = acc_shr[WIDTH-1:0];

endmodule

// File: rtl/acl_sample_filter.sv
// Periodic stability-checked capture of the SPI accelerometer word,
// averaged per axis into a filtered word with a valid strobe.
module acl_sample_filter
    import acl_filter_pkg::*;
#(
    parameter int SAMPLE_DIV = 100000,
    parameter int STABLE_CYC = 32,
    parameter int MAX_RETRY  = 3,
    parameter int AVG_LOG2   = 3
) (
    input  logic              CLK100MHZ,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [PACK_W-1:0] acl_data,
    output logic [PACK_W-1:0] filt_acl_data,
    output logic              filt_valid,
    output logic [7:0]        drop_count,
    output logic              busy
);

    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int NW = AVG_LOG2;

    acl_state_e        state_q;
    acl_state_e        state_d;
    logic [TW-1:0]     tick_cnt_q;
    logic [TW-1:0]     tick_cnt_d;
    logic [PACK_W-1:0] snap_q;
    logic [PACK_W-1:0] snap_d;
    logic [SW-1:0]     stable_q;
    logic [SW-1:0]     stable_d;
    logic [RW-1:0]     retry_q;
    logic [RW-1:0]     retry_d;
    logic [NW-1:0]     smp_q;
    logic [NW-1:0]     smp_d;
    logic [7:0]        drop_q;
    logic [7:0]        drop_d;
    logic [PACK_W-1:0] filt_q;
    logic [PACK_W-1:0] filt_d;
    logic              valid_q;
    logic              valid_d;

    logic              tick;
    logic              match;
    logic              last_stable;
    logic              retry_max;
    logic              last_smp;
    logic [PACK_W-1:0] avg_pack;

    logic snap_load;
    logic stable_clr;
    logic stable_inc;
    logic retry_clr;
    logic retry_inc;
    logic drop_inc;
    logic acc_add;
    logic acc_clr;
    logic smp_inc;
    logic emit;

    assign tick        = (tick_cnt_q == TW'(SAMPLE_DIV - 1));
    assign match       = (acl_data == snap_q);
    assign last_stable = (stable_q == SW'(STABLE_CYC - 1));
    assign retry_max   = (retry_q == RW'(MAX_RETRY));
    assign last_smp    = (smp_q == {NW{1'b1}});

    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tick) state_d = ST_CONFIRM;
                end
                ST_CONFIRM: begin
                    if (!match) begin
                        if (retry_max) state_d = ST_IDLE;
                    end else if (last_stable) begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    state_d = last_smp ? ST_EMIT : ST_IDLE;
                end
                ST_EMIT: begin
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        snap_load  = 1'b0;
        stable_clr = 1'b0;
        stable_inc = 1'b0;
        retry_clr  = 1'b0;
        retry_inc  = 1'b0;
        drop_inc   = 1'b0;
        acc_add    = 1'b0;
        acc_clr    = 1'b0;
        smp_inc    = 1'b0;
        emit       = 1'b0;
        // Dropping enable discards the partial average in every state.
        if (!enable) begin
            acc_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        snap_load  = 1'b1;
                        stable_clr = 1'b1;
                        retry_clr  = 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (!match) begin
                        if (retry_max) begin
                            drop_inc = 1'b1;
                        end else begin
                            snap_load  = 1'b1;
                            stable_clr = 1'b1;
                            retry_inc  = 1'b1;
                        end
                    end else begin
                        stable_inc = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    acc_add = 1'b1;
                    smp_inc = !last_smp;
                end
                ST_EMIT: begin
                    emit    = 1'b1;
                    acc_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        snap_d = snap_load ? acl_data : snap_q;

        stable_d = stable_q;
        if (stable_clr)      stable_d = '0;
        else if (stable_inc) stable_d = stable_q + 1'b1;

        retry_d = retry_q;
        if (retry_clr)      retry_d = '0;
        else if (retry_inc) retry_d = retry_q + 1'b1;

        smp_d = smp_q;
        if (acc_clr)      smp_d = '0;
        else if (smp_inc) smp_d = smp_q + 1'b1;

        drop_d = drop_q;
        if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 1'b1;

        filt_d  = emit ? avg_pack : filt_q;
        valid_d = emit;
    end

    // Valid is registered so it lands together with the updated word.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            snap_q     <= '0;
            stable_q   <= '0;
            retry_q    <= '0;
            smp_q      <= '0;
            drop_q     <= '0;
            filt_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            snap_q     <= snap_d;
            stable_q   <= stable_d;
            retry_q    <= retry_d;
            smp_q      <= smp_d;
            drop_q     <= drop_d;
            filt_q     <= filt_d;
            valid_q    <= valid_d;
        end
    end

    acl_axis_accumulator #(
        .WIDTH    (ACL_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc_x (
        .clk    (CLK100MHZ),
        .rst_n  (reset_n),
        .sample (snap_q[X_LO +: ACL_W]),
        .add    (acc_add),
        .clear  (acc_clr),
        .avg    (avg_pack[X_LO +: ACL_W])
    );

    acl_axis_accumulator #(
        .WIDTH    (ACL_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc_y (
        .clk    (CLK100MHZ),
        .rst_n  (reset_n),
        .sample (snap_q[Y_LO +: ACL_W]),
        .add    (acc_add),
        .clear  (acc_clr),
        .avg    (avg_pack[Y_LO +: ACL_W])
    );

    acl_axis_accumulator #(
        .WIDTH    (ACL_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc_z (
        .clk    (CLK100MHZ),
        .rst_n  (reset_n),
        .sample (snap_q[Z_LO +: ACL_W]),
        .add    (acc_add),
        .clear  (acc_clr),
        .avg    (avg_pack[Z_LO +: ACL_W])
    );

    assign filt_acl_data = filt_q;
    assign filt_valid    = valid_q;
    assign drop_count    = drop_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_acl_sample_filter.sv
// Directed bench for acl_sample_filter: averaging vectors plus
// glitch, instability, enable-drop and reset sequences.
module tb_acl_sample_filter;

    localparam int STABLE = 8;

    logic        CLK100MHZ = 1'b0;
    logic        reset_n   = 1'b0;
    logic        enable    = 1'b0;
    logic [44:0] acl_data  = '0;
    logic [44:0] filt_acl_data;
    logic        filt_valid;
    logic [7:0]  drop_count;
    logic        busy;

    int errs   = 0;
    int checks = 0;

    int          cyc      = 0;
    int          rise_cyc = 0;
    int          vcyc     = 0;
    int          vcnt     = 0;
    logic [44:0] vdata    = '0;
    logic        busy_d   = 1'b0;

    typedef struct {
        int x[4];
        int y[4];
        int z[4];
        int ex;
        int ey;
        int ez;
    } vec_t;

    vec_t vt[4];

    acl_sample_filter #(
        .SAMPLE_DIV (200),
        .STABLE_CYC (STABLE),
        .MAX_RETRY  (3),
        .AVG_LOG2   (2)
    ) dut (
        .CLK100MHZ     (CLK100MHZ),
        .reset_n       (reset_n),
        .enable        (enable),
        .acl_data      (acl_data),
        .filt_acl_data (filt_acl_data),
        .filt_valid    (filt_valid),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(negedge CLK100MHZ) begin
        cyc    <= cyc + 1;
        busy_d <= busy;
        if (busy && !busy_d) rise_cyc <= cyc;
        if (filt_valid) begin
            vcnt  <= vcnt + 1;
            vdata <= filt_acl_data;
            vcyc  <= cyc;
        end
    end

    function automatic logic [44:0] pk(input int x, input int y, input int z);
        logic [14:0] a;
        logic [14:0] b;
        logic [14:0] c;
        a = x[14:0];
        b = y[14:0];
        c = z[14:0];
        return {c, b, a};
    endfunction

    function automatic int fld(input logic [44:0] w, input int lo);
        logic signed [14:0] f;
        f = w[lo +: 15];
        return int'(f);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int maxc, input string nm);
        int n;
        n = 0;
        while (busy !== lvl && n < maxc) begin
            @(negedge CLK100MHZ);
            n++;
        end
        if (busy !== lvl) chk({nm, "_timeout"}, int'(busy), int'(lvl));
    endtask

    task automatic feed(input int x, input int y, input int z);
        acl_data = pk(x, y, z);
        wait_busy(1'b1, 300, "feed_rise");
        wait_busy(1'b0, 60, "feed_fall");
    endtask

    task automatic chk_word(input string nm, input int ex, input int ey, input int ez);
        chk({nm, "_x"}, fld(vdata, 0), ex);
        chk({nm, "_y"}, fld(vdata, 15), ey);
        chk({nm, "_z"}, fld(vdata, 30), ez);
    endtask

    initial begin
        int v0;
        int d0;
        int falls;
        int n;
        logic bprev;

        vt[0].x = '{100, 100, 100, 100};
        vt[0].y = '{-50, -50, -50, -50};
        vt[0].z = '{1024, 1024, 1024, 1024};
        vt[0].ex = 100; vt[0].ey = -50; vt[0].ez = 1024;
        vt[1].x = '{-1, -1, -1, -2};
        vt[1].y = '{3, 3, 3, 4};
        vt[1].z = '{0, 0, 0, 1};
        vt[1].ex = -2; vt[1].ey = 3; vt[1].ez = 0;
        vt[2].x = '{-16384, -16384, -16384, -16384};
        vt[2].y = '{16383, 16383, 16383, 16383};
        vt[2].z = '{-16384, 16383, -16384, 16383};
        vt[2].ex = -16384; vt[2].ey = 16383; vt[2].ez = -1;
        vt[3].x = '{7, 0, 0, 0};
        vt[3].y = '{-7, 0, 0, 0};
        vt[3].z = '{1, 2, 3, 5};
        vt[3].ex = 1; vt[3].ey = -2; vt[3].ez = 2;

        enable   = 1'b1;
        acl_data = pk(5, 6, 7);
        repeat (4) @(negedge CLK100MHZ);
        chk("rst_filt", int'(filt_acl_data != 0), 0);
        chk("rst_valid", int'(filt_valid), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1;

        // Averaging table: one pulse per four accepted samples.
        for (int i = 0; i < 4; i++) begin
            v0 = vcnt;
            for (int k = 0; k < 4; k++) begin
                feed(vt[i].x[k], vt[i].y[k], vt[i].z[k]);
                if (k == 2) begin
                    repeat (2) @(negedge CLK100MHZ);
                    chk($sformatf("v%0d_early", i), vcnt - v0, 0);
                end
            end
            repeat (2) @(negedge CLK100MHZ);
            chk($sformatf("v%0d_pulses", i), vcnt - v0, 1);
            // filt_valid follows EMIT by one cycle; busy rises one after tick.
            chk($sformatf("v%0d_lat", i), vcyc - rise_cyc, STABLE + 2);
            chk_word($sformatf("v%0d", i), vt[i].ex, vt[i].ey, vt[i].ez);
            chk($sformatf("v%0d_drop", i), int'(drop_count), 0);
        end

        // Single glitch 3 cycles into each attempt: the new value is taken.
        v0 = vcnt;
        for (int k = 0; k < 4; k++) begin
            acl_data = pk(40, 0, 0);
            wait_busy(1'b1, 300, "gl_rise");
            repeat (3) @(negedge CLK100MHZ);
            acl_data = pk(41, 0, 0);
            wait_busy(1'b0, 60, "gl_fall");
        end
        repeat (2) @(negedge CLK100MHZ);
        chk("gl_pulses", vcnt - v0, 1);
        chk("gl_lat", vcyc - rise_cyc, STABLE + 6);
        chk_word("gl", 41, 0, 0);
        chk("gl_drop", int'(drop_count), 0);

        // Enable drop in CONFIRM after three accepted samples.
        v0 = vcnt;
        for (int k = 0; k < 3; k++) feed(5, 5, 5);
        acl_data = pk(5, 5, 5);
        wait_busy(1'b1, 300, "en_rise");
        repeat (2) @(negedge CLK100MHZ);
        enable = 1'b0;
        @(negedge CLK100MHZ);
        chk("en_busy", int'(busy), 0);
        chk("en_hold_x", fld(filt_acl_data, 0), 41);
        repeat (3) @(negedge CLK100MHZ);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) feed(-9, 9, 200);
        repeat (2) @(negedge CLK100MHZ);
        chk("en_early", vcnt - v0, 0);
        chk("en_hold_y", fld(filt_acl_data, 15), 0);
        feed(-9, 9, 200);
        repeat (2) @(negedge CLK100MHZ);
        chk("en_pulses", vcnt - v0, 1);
        chk_word("en", -9, 9, 200);
        chk("en_drop", int'(drop_count), 0);

        // Instability: toggle bit 0 every two cycles for 300 attempts.
        v0       = vcnt;
        d0       = int'(drop_count);
        acl_data = pk(1, 2, 3);
        falls    = 0;
        n        = 0;
        bprev    = busy;
        while (falls < 300 && n < 61000) begin
            @(negedge CLK100MHZ);
            n++;
            if (n % 2 == 0) acl_data[0] = ~acl_data[0];
            if (bprev && !busy) begin
                falls++;
                if (falls == 1) chk("inst_first", int'(drop_count), d0 + 1);
            end
            bprev = busy;
        end
        chk("inst_attempts", falls, 300);
        chk("inst_sat", int'(drop_count), 255);
        chk("inst_pulses", vcnt - v0, 0);
        acl_data = pk(1, 2, 3);
        wait_busy(1'b0, 60, "inst_idle");

        // Reset after two accepted samples; no carryover afterwards.
        for (int k = 0; k < 2; k++) feed(100, 100, 100);
        @(negedge CLK100MHZ);
        reset_n = 1'b0;
        #1;
        chk("mr_filt", int'(filt_acl_data != 0), 0);
        chk("mr_drop", int'(drop_count), 0);
        chk("mr_valid", int'(filt_valid), 0);
        chk("mr_busy", int'(busy), 0);
        repeat (3) @(negedge CLK100MHZ);
        reset_n = 1'b1;
        v0 = vcnt;
        for (int k = 0; k < 3; k++) feed(8, 0, 0);
        repeat (2) @(negedge CLK100MHZ);
        chk("mr_early", vcnt - v0, 0);
        feed(8, 0, 0);
        repeat (2) @(negedge CLK100MHZ);
        chk("mr_pulses", vcnt - v0, 1);
        chk_word("mr", 8, 0, 0);

        repeat (5) @(negedge CLK100MHZ);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
